// File: rtl/neopix_tx.sv
// -----------------------------------------------------------------------------
// neopix_tx -- WS2812 / NeoPixel serializer.
//
// On a start pulse the block pulls NUM_LEDS 24-bit GRB words from a
// valid/ready stream and shifts each one out MSB-first as NRZ pulse pairs:
// the line is high for T1H ('1') or T0H ('0') cycles and then low for the
// remainder of a TBIT-cycle bit slot. After the last bit the line is held low
// for TRST cycles so the strip latches, then a one-cycle done pulse is given.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   start      one-cycle frame request, honoured only while idle
//   pix_data   GRB pixel word, bit 23 transmitted first
//   pix_valid  pix_data valid
//   pix_ready  word accepted on a cycle with pix_valid && pix_ready
//   dout       registered NeoPixel data line
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse when the latch gap completes
//   underflow  one-cycle pulse on the first cycle of each input stall
// -----------------------------------------------------------------------------
module neopix_tx #(
  parameter int NUM_LEDS = 4,
  parameter int T0H      = 20,
  parameter int T1H      = 40,
  parameter int TBIT     = 63,
  parameter int TRST     = 2750
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        done,
  output logic        underflow
);

  localparam int CYC_MAX = (TBIT > TRST) ? TBIT : TRST;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int PIX_W   = $clog2(NUM_LEDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_e;

  state_e             state_q,    state_d;
  logic [CYC_W-1:0]   cyc_q,      cyc_d;
  logic [4:0]         bit_idx_q,  bit_idx_d;
  logic [PIX_W-1:0]   pix_left_q, pix_left_d;
  logic [23:0]        shift_q,    shift_d;
  logic               dout_q,     dout_d;
  logic               done_q,     done_d;
  logic               stall_q,    stall_d;

  // High and low durations of the bit currently at the top of the shifter.
  logic [CYC_W-1:0]   th;
  logic [CYC_W-1:0]   tl;

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_idx_d  = bit_idx_q;
    pix_left_d = pix_left_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    th = shift_q[23] ? CYC_W'(T1H) : CYC_W'(T0H);
    // Bit 0 gives one low cycle to the LOAD (or LATCH) state that follows,
    // keeping the bit period at exactly TBIT across pixel boundaries.
    tl = CYC_W'(TBIT) - th - ((bit_idx_q == 5'd0) ? CYC_W'(1) : CYC_W'(0));

    unique case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped; the next cycle
        // is the first one that can begin a new frame.
        if (start && !done_q) begin
          state_d    = S_LOAD;
          pix_left_d = PIX_W'(NUM_LEDS);
        end
      end

      S_LOAD: begin
        if (pix_valid) begin
          shift_d    = pix_data;
          bit_idx_d  = 5'd23;
          cyc_d      = '0;
          pix_left_d = pix_left_q - PIX_W'(1);
          state_d    = S_HIGH;
        end
      end

      S_HIGH: begin
        if (cyc_q == th - CYC_W'(1)) begin
          cyc_d   = '0;
          state_d = S_LOW;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      S_LOW: begin
        if (cyc_q == tl - CYC_W'(1)) begin
          cyc_d = '0;
          if (bit_idx_q != 5'd0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 5'd1;
            state_d   = S_HIGH;
          end else if (pix_left_q != '0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_LATCH;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      S_LATCH: begin
        if (cyc_q == CYC_W'(TRST - 1)) begin
          cyc_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The line is driven from the next state so that dout_q is high exactly
    // while state_q is HIGH, straight from a flop with no decode glitches.
    dout_d  = (state_d == S_HIGH);
    stall_d = (state_q == S_LOAD) && !pix_valid;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_idx_q  <= '0;
      pix_left_q <= '0;
      shift_q    <= '0;
      dout_q     <= 1'b0;
      done_q     <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_idx_q  <= bit_idx_d;
      pix_left_q <= pix_left_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      stall_q    <= stall_d;
    end
  end

  assign pix_ready = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign underflow = pix_ready && !pix_valid && !stall_q;
  assign dout      = dout_q;
  assign done      = done_q;

endmodule

// File: tb/tb_neopix_tx.sv
// -----------------------------------------------------------------------------
// tb_neopix_tx -- scoreboard bench for neopix_tx.
//
// The driver pushes the expected pulse widths and rise-to-rise spacing of
// every bit it hands to the DUT, plus one per-frame record (latch length,
// underflow count, handshake count). A monitor on the falling clock edge
// measures dout, handshakes, underflow and done and compares against the
// queues. Inputs change 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_neopix_tx;

  localparam int NUM_LEDS = 4;
  localparam int T0H      = 20;
  localparam int T1H      = 40;
  localparam int TBIT     = 63;
  localparam int TRST     = 100;
  localparam int STALL    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        dout;
  logic        busy;
  logic        done;
  logic        underflow;

  neopix_tx #(
    .NUM_LEDS (NUM_LEDS),
    .T0H      (T0H),
    .T1H      (T1H),
    .TBIT     (TBIT),
    .TRST     (TRST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int high;   // expected high width in cycles
    int gap;    // expected cycles since previous rising edge, 0 = unchecked
  } bit_exp_t;

  typedef struct {
    int latch;  // cycles from last falling edge to done
    int ufl;    // underflow pulses in the frame
    int hs;     // ready handshakes in the frame
  } frame_exp_t;

  bit_exp_t   bit_q[$];
  frame_exp_t frame_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int latch_len(input logic [23:0] last_word);
    return TBIT - (last_word[0] ? T1H : T0H) - 1 + TRST;
  endfunction

  // ---------------------------------------------------------------- monitor
  initial begin
    int   cyc_n     = 0;
    int   rise_cyc  = 0;
    int   fall_cyc  = 0;
    int   hs_n      = 0;
    int   ufl_n     = 0;
    logic dout_prev = 1'b0;
    logic done_prev = 1'b0;
    frame_exp_t f;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (mon_en) begin
        if (pix_ready && pix_valid) hs_n++;
        if (underflow) ufl_n++;
        if (dout && !dout_prev) begin
          if (bit_q.size() == 0) fail_now("unexpected_pulse");
          else if (bit_q[0].gap != 0) check("rise_gap", cyc_n - rise_cyc, bit_q[0].gap);
          rise_cyc = cyc_n;
        end
        if (!dout && dout_prev) begin
          fall_cyc = cyc_n;
          if (bit_q.size() != 0) begin
            check("high_width", cyc_n - rise_cyc, bit_q[0].high);
            void'(bit_q.pop_front());
          end
        end
      end else begin
        hs_n  = 0;
        ufl_n = 0;
      end
      if (done) begin
        if (frame_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          f = frame_q.pop_front();
          check("latch_len", cyc_n - fall_cyc, f.latch);
          check("underflow_count", ufl_n, f.ufl);
          check("handshakes", hs_n, f.hs);
          check("busy_at_done", busy, 0);
        end
        hs_n  = 0;
        ufl_n = 0;
      end
      if (done_prev) check("done_one_cycle", done, 0);
      dout_prev = dout;
      done_prev = done;
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic push_word(input logic [23:0] w, input bit first, input bit stall);
    bit_exp_t e;
    for (int i = 23; i >= 0; i--) begin
      e.high = w[i] ? T1H : T0H;
      if (i == 23) e.gap = first ? 0 : (stall ? TBIT + STALL : TBIT);
      else         e.gap = TBIT;
      bit_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [23:0] w, input bit first, input bit stall);
    int n;
    push_word(w, first, stall);
    if (stall) begin
      pix_valid = 1'b0;
      n = 0;
      while (!pix_ready && n < 3000) begin tick(); n++; end
      if (!pix_ready) fail_now("stall_ready_timeout");
      repeat (STALL) tick();
    end
    pix_data  = w;
    pix_valid = 1'b1;
    n = 0;
    while (!pix_ready && n < 3000) begin tick(); n++; end
    if (!pix_ready) fail_now("ready_timeout");
    tick();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 4000) begin tick(); n++; end
    if (!done) fail_now("done_timeout");
  endtask

  initial begin
    logic [23:0] fa [4];
    logic [23:0] fb [4];
    logic [23:0] fc [2];
    logic [23:0] fd [4];
    fa = '{24'hAA5500, 24'h0055AA, 24'hFFFFFF, 24'h000000};
    fb = '{24'hAA0055, 24'h123456, 24'h7FFFFE, 24'h800001};
    fc = '{24'hAA0055, 24'hFFFFFF};
    fd = '{24'h0F0F0F, 24'hF0F0F0, 24'h00FF00, 24'h555555};

    rst       = 1'b1;
    start     = 1'b0;
    pix_data  = '0;
    pix_valid = 1'b0;
    repeat (3) tick();
    check("reset_dout", dout, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", pix_ready, 0);
    check("reset_underflow", underflow, 0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    check("idle_ready", pix_ready, 0);

    // Frame A: continuous stream.
    frame_q.push_back('{latch_len(fa[3]), 0, NUM_LEDS});
    pix_data  = fa[0];
    pix_valid = 1'b1;
    start_frame();
    for (int i = 0; i < 4; i++) send_word(fa[i], i == 0, 1'b0);
    pix_valid = 1'b0;
    wait_done();
    tick();

    // Frame B: stall before pixel 2, start re-pulsed mid-frame.
    frame_q.push_back('{latch_len(fb[3]), 1, NUM_LEDS});
    pix_data  = fb[0];
    pix_valid = 1'b1;
    start_frame();
    send_word(fb[0], 1'b1, 1'b0);
    send_word(fb[1], 1'b0, 1'b1);
    send_word(fb[2], 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_after_midframe_start", pix_ready, 0);
    send_word(fb[3], 1'b0, 1'b0);
    pix_valid = 1'b0;
    wait_done();

    // Frame C: start held across the done cycle; only the second cycle counts.
    pix_data  = fc[0];
    pix_valid = 1'b1;
    start     = 1'b1;
    tick();
    check("start_on_done_ignored", busy, 0);
    tick();
    start = 1'b0;
    check("start_after_done_accepted", busy, 1);
    send_word(fc[0], 1'b1, 1'b0);
    send_word(fc[1], 1'b0, 1'b0);
    repeat (5) tick();
    check("dout_high_before_reset", dout, 1);
    mon_en = 1'b0;
    bit_q.delete();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_dout", dout, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_ready", pix_ready, 0);
    pix_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    mon_en = 1'b1;

    // Frame D: full frame after the aborted one.
    frame_q.push_back('{latch_len(fd[3]), 0, NUM_LEDS});
    pix_data  = fd[0];
    pix_valid = 1'b1;
    start_frame();
    for (int i = 0; i < 4; i++) send_word(fd[i], i == 0, 1'b0);
    pix_valid = 1'b0;
    wait_done();
    repeat (5) tick();

    check("bits_outstanding", bit_q.size(), 0);
    check("frames_outstanding", frame_q.size(), 0);
    check("final_busy", busy, 0);
    check("final_dout", dout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neopix_tx.md
Name: neopix_tx

Overview:
- WS2812/NeoPixel serializer; sits directly downstream of the SPI receive/pixel buffer in de0_spi_to_neopix.
- On a start pulse, pulls NUM_LEDS 24-bit GRB words over a valid/ready stream.
- Emits each word MSB-first as NRZ high/low pulse pairs, then holds the line low for the latch (reset) gap.
- Reports busy, done and underflow.

Parameters:
- NUM_LEDS, 4, pixels per frame; range 1..65535.
- T0H, 20, clk cycles high for a '0' bit (400 ns at 50 MHz).
- T1H, 40, clk cycles high for a '1' bit (800 ns).
- TBIT, 63, total clk cycles per bit (1.26 us); must exceed T1H+1.
- TRST, 2750, clk cycles of latch low after the last bit (55 us).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame request; honoured only in IDLE.
- pix_data  in  24  GRB pixel word; bit 23 is sent first.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  word accepted on a cycle where pix_valid && pix_ready.
- dout  out  1  NeoPixel data line.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the latch gap completes.
- underflow  out  1  one-cycle pulse on the first cycle of each stall (LOAD with pix_valid low).

Behaviour:
- Reset, asynchronous: state=IDLE; dout=0, pix_ready=0, busy=0, done=0, underflow=0; all counters cleared. Reset mid-frame aborts immediately with the line low; no done pulse.
- States: IDLE, LOAD, HIGH, LOW, LATCH.
- IDLE: dout=0. start=1 -> LOAD; pix_left=NUM_LEDS.
- LOAD: dout=0; pix_ready=1 (combinational from state).
  - pix_valid=1: shift register<=pix_data, bit_idx=23, cyc=0, pix_left decrements -> HIGH.
  - pix_valid=0: stay in LOAD with the line low. Underflow pulses on the first stall cycle only. A stall longer than about 50 us latches the strip early; that is the upstream's responsibility.
- HIGH: dout=1 for Th cycles. Th=T1H if the current bit is 1, else T0H. Then -> LOW with cyc=0.
- LOW: dout=0 for Tl cycles. Tl=TBIT-Th for bits 23..1. For bit 0, Tl=TBIT-Th-1, so the following LOAD cycle completes the bit period.
  - After bits 23..1: shift left, bit_idx decrements -> HIGH.
  - After bit 0, pix_left>0 -> LOAD.
  - After bit 0, pix_left=0 -> LATCH with cyc=0. The final bit's lost cycle is absorbed into the latch gap.
- LATCH: dout=0 for TRST cycles. Then done=1 for one cycle -> IDLE. busy falls the same cycle done rises.
- Bit period is exactly TBIT cycles when pix_valid is high on entry to LOAD. Continuous stream: each pixel is exactly 24*TBIT cycles, rising edge to rising edge.
- start while busy: ignored, no queueing. start on the same cycle done pulses: ignored; a new start the next cycle is accepted.
- dout is registered with no glitches. pix_ready is never high outside LOAD.
- Counter widths: cyc is clog2(max(TBIT,TRST)+1) bits; pix_left is clog2(NUM_LEDS+1) bits.

Test Plan:
- Single frame, NUM_LEDS=1, TRST=100, word 24'hAA0055 valid continuously.
  - Required: 24 pulses with high widths 40,20,40,20,40,20,40,20, then 20x8, then 20,40,20,40,20,40,20,40 cycles.
  - Rising edges exactly 63 cycles apart; then 100+ low cycles; done one cycle; busy low.
- NUM_LEDS=4, stream AA5500, 0055AA, FFFFFF, 000000 back to back.
  - Required: exactly 4 ready handshakes; 96 bits; rising edges every 63 cycles with no gap across pixel boundaries; done once.
- Underflow: drop pix_valid for 10 cycles before pixel 2.
  - Required: underflow pulses once; dout stays low 10 extra cycles; resumes with the correct next word; frame still totals 4 pixels.
- start re-pulsed mid-frame and on the done cycle.
  - Required: ignored, no extra ready.
  - start one cycle after done begins a new frame.
- Async reset asserted in the middle of a HIGH period of pixel 2.
  - Required: dout=0 and busy=0 immediately, without waiting for a clock edge; no done; a subsequent start sends a full 4-pixel frame.
